// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_OVERFLOW_EN to add the registered signed-overflow output.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADDER_OVERFLOW_EN
   ,output logic             overflow
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             cy_q;
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q, out_valid_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             ov_q;
`endif

    logic [DIGIT-1:0] ch_s;
    logic [DIGIT:0]   ch_c;
    logic [WIDTH-1:0] slice_w, sum_d;
    logic             last;

    // Operands shift right each RUN cycle so the active slice is always the low DIGIT bits.
    always_comb begin
        ch_s    = '0;
        ch_c    = '0;
        ch_c[0] = cy_q;
        for (int i = 0; i < DIGIT; i++) begin
            ch_s[i]   = a_q[i] ^ b_q[i] ^ ch_c[i];
            ch_c[i+1] = (a_q[i] & b_q[i]) | (ch_c[i] & (a_q[i] ^ b_q[i]));
        end
        slice_w = WIDTH'(ch_s) << (WIDTH - DIGIT);
        sum_d   = (sum_q >> DIGIT) | slice_w;
        last    = (cnt_q == CW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cy_q        <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ov_q        <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= A;
                        b_q        <= sub ? ~B : B;
                        cy_q       <= sub ? ~C : C;
                        sum_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        ov_q       <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    sum_q <= sum_d;
                    cy_q  <= ch_c[DIGIT];
                    if (last) begin
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        ov_q        <= ch_c[DIGIT-1] ^ ch_c[DIGIT];
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = cy_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign overflow  = ov_q;
`endif

endmodule
